// File: rtl/mem_master_pkg.sv
// -----------------------------------------------------------------------------
// mem_master_pkg
// Shared types and constants for the byte-wide RAM bus initiator.
//   state_t     : master FSM state encoding
//   SIZE_BYTE/
//   SIZE_WORD   : encoding of the CPU 'size' request field
//   join_bytes  : assembles a 16-bit word from the bytes read at A and A+1
// -----------------------------------------------------------------------------
package mem_master_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD0  = 3'd1,
        RD1  = 3'd2,
        RD2  = 3'd3,
        WR0  = 3'd4,
        WR1  = 3'd5
    } state_t;

    localparam logic SIZE_BYTE = 1'b0;
    localparam logic SIZE_WORD = 1'b1;

    // at_a is the byte stored at address A, at_a1 the byte at A+1.
    function automatic logic [15:0] join_bytes(input logic [7:0] at_a,
                                               input logic [7:0] at_a1,
                                               input logic       big_endian);
        return big_endian ? {at_a, at_a1} : {at_a1, at_a};
    endfunction

endpackage

// File: rtl/mem_master_if.sv
// -----------------------------------------------------------------------------
// mem_master_if
// Byte-wide synchronous RAM port.
//   mem_ce    : chip enable            (master -> RAM)
//   mem_wre   : write enable           (master -> RAM)
//   mem_addr  : byte address, ADDR_W   (master -> RAM)
//   mem_wdata : write byte             (master -> RAM)
//   mem_rdata : read byte              (RAM -> master), only meaningful while
//               mem_ce=1 in the cycle after a read was latched
// -----------------------------------------------------------------------------
interface mem_master_if #(
    parameter int ADDR_W = 16
);
    logic              mem_ce;
    logic              mem_wre;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    modport master (
        output mem_ce, mem_wre, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_ce, mem_wre, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_master.sv
// -----------------------------------------------------------------------------
// mem_master
// CPU-to-RAM bus initiator. Accepts one byte or 16-bit word request at a time
// and performs it as one or two byte accesses on a synchronous byte-wide RAM
// (low address A first, then A+1). Read data returns with a one-cycle done.
//   clk, rst  : clock, synchronous active-high reset
//   req       : request strobe, accepted when req & ready
//   we, size  : 1 = write / 0 = read; 0 = byte / 1 = word
//   addr      : byte address (ADDR_W)
//   wdata     : write data, byte writes use [7:0]
//   ready     : high while idle
//   done      : one-cycle completion pulse
//   rdata     : read result, held until the next read completes
//   mem       : RAM port (master modport)
// -----------------------------------------------------------------------------
module mem_master
    import mem_master_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic              size,
    input  logic [ADDR_W-1:0] addr,
    input  logic [15:0]       wdata,
    output logic              ready,
    output logic              done,
    output logic [15:0]       rdata,
    mem_master_if.master      mem
);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] la;          // latched address
    logic [15:0]       ld;          // latched write data
    logic              lsize;       // latched size
    logic [7:0]        first_q;     // byte read at A while a word read is in flight
    logic              last_access; // current state is the final access of the request
    logic [ADDR_W-1:0] la_inc;
    logic              is_word;
    logic [7:0]        wbyte_a;
    logic [7:0]        wbyte_a1;

    assign ready   = (state == IDLE);
    assign is_word = (lsize == SIZE_WORD);
    // Wraps modulo 2^ADDR_W, so a word at the top address continues at 0.
    assign la_inc  = la + ADDR_W'(1);

    // Byte destined for A and for A+1; a byte write always takes wdata[7:0].
    assign wbyte_a  = (is_word && BIG_ENDIAN) ? ld[15:8] : ld[7:0];
    assign wbyte_a1 = BIG_ENDIAN ? ld[7:0] : ld[15:8];

    // Next state and RAM drive, decoded from state and the latched request.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a signal unassigned, which would infer a latch.
        state_nxt     = state;
        last_access   = 1'b0;
        mem.mem_ce    = 1'b0;
        mem.mem_wre   = 1'b0;
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;

        case (state)
            IDLE: begin
                if (req) state_nxt = we ? WR0 : RD0;
            end
            RD0: begin
                mem.mem_ce   = 1'b1;
                mem.mem_addr = la;
                state_nxt    = RD1;
            end
            RD1: begin
                // ce stays high: the byte latched at the end of RD0 is only
                // visible while the RAM stays enabled.
                mem.mem_ce   = 1'b1;
                mem.mem_addr = is_word ? la_inc : la;
                state_nxt    = is_word ? RD2 : IDLE;
                last_access  = !is_word;
            end
            RD2: begin
                mem.mem_ce   = 1'b1;
                mem.mem_addr = la_inc;
                state_nxt    = IDLE;
                last_access  = 1'b1;
            end
            WR0: begin
                mem.mem_ce    = 1'b1;
                mem.mem_wre   = 1'b1;
                mem.mem_addr  = la;
                mem.mem_wdata = wbyte_a;
                state_nxt     = is_word ? WR1 : IDLE;
                last_access   = !is_word;
            end
            WR1: begin
                mem.mem_ce    = 1'b1;
                mem.mem_wre   = 1'b1;
                mem.mem_addr  = la_inc;
                mem.mem_wdata = wbyte_a1;
                state_nxt     = IDLE;
                last_access   = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            state   <= IDLE;
            la      <= '0;
            ld      <= '0;
            lsize   <= SIZE_BYTE;
            first_q <= '0;
            done    <= 1'b0;
            rdata   <= '0;
        end else begin
            state <= state_nxt;
            done  <= last_access;

            if (req && ready) begin
                la    <= addr;
                ld    <= wdata;
                lsize <= size;
            end

            // Capture cycles: the RAM shows the byte latched one edge earlier.
            if (state == RD1) begin
                if (is_word) first_q <= mem.mem_rdata;
                else         rdata   <= {8'h00, mem.mem_rdata};
            end
            if (state == RD2) begin
                rdata <= join_bytes(first_q, mem.mem_rdata, BIG_ENDIAN);
            end
        end
    end

endmodule

// File: tb/tb_mem_master.sv
// -----------------------------------------------------------------------------
// tb_mem_master
// Drives a little-endian and a big-endian mem_master from the same CPU
// stimulus, each talking to its own behavioural synchronous byte RAM.
// Expected values are hand-computed per instance in the vector table and in
// the directed sequences below.
// -----------------------------------------------------------------------------
module tb_mem_master;
    import mem_master_pkg::*;

    logic        clk;
    logic        rst;
    logic        req;
    logic        we;
    logic        size;
    logic [15:0] addr;
    logic [15:0] wdata;

    logic        ready_le, done_le, ready_be, done_be;
    logic [15:0] rdata_le, rdata_be;

    int n_cmp  = 0;
    int n_fail = 0;

    mem_master_if #(.ADDR_W(16)) bus_le ();
    mem_master_if #(.ADDR_W(16)) bus_be ();

    mem_master #(.ADDR_W(16), .BIG_ENDIAN(1'b0)) dut_le (
        .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .addr(addr),
        .wdata(wdata), .ready(ready_le), .done(done_le), .rdata(rdata_le),
        .mem(bus_le)
    );

    mem_master #(.ADDR_W(16), .BIG_ENDIAN(1'b1)) dut_be (
        .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .addr(addr),
        .wdata(wdata), .ready(ready_be), .done(done_be), .rdata(rdata_be),
        .mem(bus_be)
    );

    // Behavioural RAMs: a read is latched at the edge ending a ce=1/wre=0
    // cycle and shown only while ce stays high. 8'hEE stands in for the
    // floating bus so a capture with ce low returns obvious garbage.
    // NOTE: the RAM arrays are deliberately not reset; a reset loop over a
    // memory is costly and the bench never reads a location it has not written.
    logic [7:0] ram_le [0:65535];
    logic [7:0] ram_be [0:65535];
    logic [7:0] rdq_le, rdq_be;

    always @(posedge clk) begin
        if (bus_le.mem_ce) begin
            if (bus_le.mem_wre) ram_le[bus_le.mem_addr] <= bus_le.mem_wdata;
            else                rdq_le <= ram_le[bus_le.mem_addr];
        end
        if (bus_be.mem_ce) begin
            if (bus_be.mem_wre) ram_be[bus_be.mem_addr] <= bus_be.mem_wdata;
            else                rdq_be <= ram_be[bus_be.mem_addr];
        end
    end

    assign bus_le.mem_rdata = bus_le.mem_ce ? rdq_le : 8'hEE;
    assign bus_be.mem_rdata = bus_be.mem_ce ? rdq_be : 8'hEE;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        we;
        logic        size;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          lat;     // cycles from acceptance edge to done
        logic [15:0] exp_le;  // rdata at done, little-endian instance
        logic [15:0] exp_be;  // rdata at done, big-endian instance
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic w, input logic s,
                         input logic [15:0] a, input logic [15:0] d);
        req   = r;
        we    = w;
        size  = s;
        addr  = a;
        wdata = d;
    endtask

    // Called #1 after the acceptance edge; returns #1 after the done edge.
    task automatic wait_done(input string tag, input int exp_lat,
                             input logic [15:0] exp_le, input logic [15:0] exp_be);
        int lat;
        lat = 0;
        check({tag, " ce_after_accept"}, {30'd0, bus_le.mem_ce, bus_be.mem_ce}, 32'd3);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            if (done_le || done_be) begin
                lat = k;
                break;
            end
            check({tag, " ce_in_flight"}, {30'd0, bus_le.mem_ce, bus_be.mem_ce}, 32'd3);
        end
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " done_both"}, {30'd0, done_le, done_be}, 32'd3);
        check({tag, " ready_at_done"}, {30'd0, ready_le, ready_be}, 32'd3);
        check({tag, " rdata_le"}, {16'd0, rdata_le}, {16'd0, exp_le});
        check({tag, " rdata_be"}, {16'd0, rdata_be}, {16'd0, exp_be});
    endtask

    vec_t vecs [12];
    vec_t b2b  [6];

    initial begin
        vecs[0]  = '{1'b1, SIZE_BYTE, 16'h0010, 16'h00AB, 1, 16'h0000, 16'h0000};
        vecs[1]  = '{1'b0, SIZE_BYTE, 16'h0010, 16'h0000, 2, 16'h00AB, 16'h00AB};
        vecs[2]  = '{1'b1, SIZE_WORD, 16'h0020, 16'h1234, 2, 16'h00AB, 16'h00AB};
        vecs[3]  = '{1'b0, SIZE_WORD, 16'h0020, 16'h0000, 3, 16'h1234, 16'h1234};
        vecs[4]  = '{1'b0, SIZE_BYTE, 16'h0020, 16'h0000, 2, 16'h0034, 16'h0012};
        vecs[5]  = '{1'b0, SIZE_BYTE, 16'h0021, 16'h0000, 2, 16'h0012, 16'h0034};
        vecs[6]  = '{1'b1, SIZE_WORD, 16'hFFFF, 16'hBEEF, 2, 16'h0012, 16'h0034};
        vecs[7]  = '{1'b0, SIZE_WORD, 16'hFFFF, 16'h0000, 3, 16'hBEEF, 16'hBEEF};
        vecs[8]  = '{1'b0, SIZE_BYTE, 16'h0000, 16'h0000, 2, 16'h00BE, 16'h00EF};
        vecs[9]  = '{1'b1, SIZE_BYTE, 16'h0030, 16'h55CD, 1, 16'h00BE, 16'h00EF};
        vecs[10] = '{1'b1, SIZE_BYTE, 16'h0031, 16'h0077, 1, 16'h00BE, 16'h00EF};
        vecs[11] = '{1'b0, SIZE_WORD, 16'h0030, 16'h0000, 3, 16'h77CD, 16'hCD77};

        b2b[0] = '{1'b1, SIZE_BYTE, 16'h0040, 16'h0011, 1, 16'h77CD, 16'hCD77};
        b2b[1] = '{1'b0, SIZE_BYTE, 16'h0040, 16'h0000, 2, 16'h0011, 16'h0011};
        b2b[2] = '{1'b1, SIZE_WORD, 16'h0042, 16'hA5C3, 2, 16'h0011, 16'h0011};
        b2b[3] = '{1'b0, SIZE_WORD, 16'h0042, 16'h0000, 3, 16'hA5C3, 16'hA5C3};
        b2b[4] = '{1'b1, SIZE_BYTE, 16'h0044, 16'h0099, 1, 16'hA5C3, 16'hA5C3};
        b2b[5] = '{1'b0, SIZE_BYTE, 16'h0044, 16'h0000, 2, 16'h0099, 16'h0099};

        // Reset state.
        rst = 1'b1;
        drive(1'b0, 1'b0, SIZE_BYTE, 16'h0000, 16'h0000);
        repeat (3) @(posedge clk);
        #1;
        check("reset ready",   {30'd0, ready_le, ready_be}, 32'd3);
        check("reset done",    {30'd0, done_le, done_be}, 32'd0);
        check("reset rdata",   {rdata_le, rdata_be}, 32'd0);
        check("reset ce_wre",  {28'd0, bus_le.mem_ce, bus_le.mem_wre, bus_be.mem_ce, bus_be.mem_wre}, 32'd0);
        check("reset addr",    {bus_le.mem_addr, bus_be.mem_addr}, 32'd0);
        check("reset wdata",   {16'd0, bus_le.mem_wdata, bus_be.mem_wdata}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Isolated requests from the vector table.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(1'b1, vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wdata);
            @(posedge clk);
            #1;
            req = 1'b0;
            wait_done($sformatf("vec%0d", i), vecs[i].lat, vecs[i].exp_le, vecs[i].exp_be);
        end

        // Byte placement in RAM, including the wrap from 0xFFFF to 0x0000.
        check("ram_le[0020]", {24'd0, ram_le[16'h0020]}, 32'h34);
        check("ram_le[0021]", {24'd0, ram_le[16'h0021]}, 32'h12);
        check("ram_be[0020]", {24'd0, ram_be[16'h0020]}, 32'h12);
        check("ram_be[0021]", {24'd0, ram_be[16'h0021]}, 32'h34);
        check("ram_le[FFFF]", {24'd0, ram_le[16'hFFFF]}, 32'hEF);
        check("ram_le[0000]", {24'd0, ram_le[16'h0000]}, 32'hBE);
        check("ram_be[FFFF]", {24'd0, ram_be[16'hFFFF]}, 32'hBE);
        check("ram_be[0000]", {24'd0, ram_be[16'h0000]}, 32'hEF);

        // req held high: each new request is accepted on the edge ending the
        // done cycle; inputs switch to the next request right after acceptance.
        @(negedge clk);
        drive(1'b1, b2b[0].we, b2b[0].size, b2b[0].addr, b2b[0].wdata);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (i < 5) drive(1'b1, b2b[i+1].we, b2b[i+1].size, b2b[i+1].addr, b2b[i+1].wdata);
            else       req = 1'b0;
            wait_done($sformatf("b2b%0d", i), b2b[i].lat, b2b[i].exp_le, b2b[i].exp_be);
        end
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("b2b idle%0d done/ready", k),
                  {28'd0, done_le, done_be, ready_le, ready_be}, 32'd3);
        end
        check("b2b ram_le[0042]", {24'd0, ram_le[16'h0042]}, 32'hC3);
        check("b2b ram_be[0042]", {24'd0, ram_be[16'h0042]}, 32'hA5);

        // A different request presented while busy is ignored.
        @(negedge clk);
        drive(1'b1, 1'b0, SIZE_WORD, 16'h0020, 16'h0000);
        @(posedge clk);
        #1;
        drive(1'b1, 1'b1, SIZE_WORD, 16'h0030, 16'hFFFF);
        wait_done("busy_ignore", 3, 16'h1234, 16'h1234);
        req = 1'b0;
        @(posedge clk);
        #1;
        check("busy_ignore idle", {30'd0, ready_le, ready_be}, 32'd3);
        check("busy_ignore ram_le[0030]", {24'd0, ram_le[16'h0030]}, 32'hCD);
        check("busy_ignore ram_be[0031]", {24'd0, ram_be[16'h0031]}, 32'h77);

        // Reset during RD1 of a word read.
        @(negedge clk);
        drive(1'b1, 1'b0, SIZE_WORD, 16'h0042, 16'h0000);
        @(posedge clk);
        #1;
        req = 1'b0;
        @(posedge clk);
        #1;
        check("midrst busy_in_rd1", {30'd0, ready_le, ready_be}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst ready", {30'd0, ready_le, ready_be}, 32'd3);
        check("midrst ce",    {30'd0, bus_le.mem_ce, bus_be.mem_ce}, 32'd0);
        check("midrst done",  {30'd0, done_le, done_be}, 32'd0);
        check("midrst rdata", {rdata_le, rdata_be}, 32'd0);
        @(posedge clk);
        #1;
        check("midrst done_later", {30'd0, done_le, done_be}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Normal operation resumes after the aborted read.
        @(negedge clk);
        drive(1'b1, 1'b0, SIZE_WORD, 16'h0042, 16'h0000);
        @(posedge clk);
        #1;
        req = 1'b0;
        wait_done("after_rst", 3, 16'hA5C3, 16'hA5C3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
